// File: rtl/booth_digit_sequencer.sv
// Radix-4 Booth encoder/sequencer: accepts a multiplier operand and emits one
// {shift, neg, zero} Booth digit per handshake, LSB group first.
module booth_digit_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_multiplier,
    input  logic             in_signed,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             dig_shift,
    output logic             dig_neg,
    output logic             dig_zero,
    output logic [IDX_W-1:0] dig_index,
    output logic             dig_last
);

    localparam int unsigned SW = WIDTH + 3;
    localparam logic [IDX_W-1:0] LAST_SIGNED   = IDX_W'(WIDTH / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_UNSIGNED = IDX_W'(WIDTH / 2);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [SW-1:0]    s, s_d;
    logic [IDX_W-1:0] last_idx, last_idx_d;
    logic [IDX_W-1:0] idx_d;
    logic             shift_d, neg_d, zero_d, last_d;
    logic [1:0]       ext;

    // Triplet {b(2k+1), b(2k), b(2k-1)} -> {shift, neg, zero}
    function automatic logic [2:0] booth(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: booth = 3'b000;
            3'b011:         booth = 3'b100;
            3'b100:         booth = 3'b110;
            3'b101, 3'b110: booth = 3'b010;
            default:        booth = 3'b001;
        endcase
    endfunction

    assign ext       = in_signed ? {2{in_multiplier[WIDTH-1]}} : 2'b00;
    assign in_ready  = (state == IDLE);
    assign dig_valid = (state == EMIT);

    // Next-state and next-digit decode; digit outputs are registered so the
    // decode targets the triplet that will sit at S[2:0] after this edge.
    always_comb begin
        state_d    = state;
        s_d        = s;
        last_idx_d = last_idx;
        idx_d      = dig_index;
        shift_d    = dig_shift;
        neg_d      = dig_neg;
        zero_d     = dig_zero;
        last_d     = dig_last;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s_d                      = {ext, in_multiplier, 1'b0};
                    last_idx_d               = in_signed ? LAST_SIGNED : LAST_UNSIGNED;
                    idx_d                    = '0;
                    {shift_d, neg_d, zero_d} = booth({in_multiplier[1:0], 1'b0});
                    last_d                   = 1'b0;
                    state_d                  = EMIT;
                end
            end
            EMIT: begin
                if (dig_ready) begin
                    if (dig_last) begin
                        state_d                  = IDLE;
                        s_d                      = '0;
                        idx_d                    = '0;
                        {shift_d, neg_d, zero_d} = 3'b000;
                        last_d                   = 1'b0;
                    end else begin
                        s_d                      = {{2{s[SW-1]}}, s[SW-1:2]};
                        idx_d                    = dig_index + 1'b1;
                        {shift_d, neg_d, zero_d} = booth(s[4:2]);
                        last_d                   = (idx_d == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, scan register and registered digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            last_idx  <= '0;
            dig_index <= '0;
            dig_shift <= 1'b0;
            dig_neg   <= 1'b0;
            dig_zero  <= 1'b0;
            dig_last  <= 1'b0;
        end else begin
            state     <= state_d;
            s         <= s_d;
            last_idx  <= last_idx_d;
            dig_index <= idx_d;
            dig_shift <= shift_d;
            dig_neg   <= neg_d;
            dig_zero  <= zero_d;
            dig_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// Directed and random bench for booth_digit_sequencer (WIDTH=8).
module tb_booth_digit_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_multiplier;
    logic       in_signed;
    logic       dig_valid;
    logic       dig_ready;
    logic       dig_shift;
    logic       dig_neg;
    logic       dig_zero;
    logic [2:0] dig_index;
    logic       dig_last;

    int vectors     = 0;
    int miscompares = 0;

    booth_digit_sequencer #(.WIDTH(8), .IDX_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_multiplier (in_multiplier),
        .in_signed     (in_signed),
        .dig_valid     (dig_valid),
        .dig_ready     (dig_ready),
        .dig_shift     (dig_shift),
        .dig_neg       (dig_neg),
        .dig_zero      (dig_zero),
        .dig_index     (dig_index),
        .dig_last      (dig_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle"}, {in_ready, dig_valid, dig_shift, dig_neg, dig_zero, dig_index, dig_last},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    endtask

    // exp holds digit k at [3k+:3], each {shift, neg, zero}
    task automatic run_directed(input string tag, input logic [7:0] v, input logic sg,
                                input logic [14:0] exp, input int n);
        in_multiplier = v;
        in_signed     = sg;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            check({tag, " digit"}, {dig_valid, dig_shift, dig_neg, dig_zero},
                  {1'b1, exp[3*k +: 3]});
            check({tag, " index"}, {29'd0, dig_index}, k);
            check({tag, " last"}, {31'd0, dig_last}, (k == n - 1) ? 1 : 0);
            tick();
        end
        check_idle(tag);
    endtask

    function automatic int digit_value(input logic sh, input logic ng, input logic z);
        int m;
        m = sh ? 2 : 1;
        if (z) return 0;
        return ng ? -m : m;
    endfunction

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_multiplier = '0;
        in_signed     = 1'b0;
        dig_ready     = 1'b1;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post-reset");

        // Basic digit streams
        run_directed("5A_s", 8'h5A, 1'b1, {3'b000, 3'b000, 3'b100, 3'b010, 3'b110}, 4);
        run_directed("FF_s", 8'hFF, 1'b1, {3'b000, 3'b001, 3'b001, 3'b001, 3'b010}, 4);
        run_directed("FF_u", 8'hFF, 1'b0, {3'b000, 3'b001, 3'b001, 3'b001, 3'b010}, 5);
        run_directed("80_s", 8'h80, 1'b1, {3'b000, 3'b110, 3'b001, 3'b001, 3'b001}, 4);
        run_directed("00_s", 8'h00, 1'b1, {3'b000, 3'b001, 3'b001, 3'b001, 3'b001}, 4);

        // Backpressure on digit 1 of 0x5A with stray in_valid pulses
        in_multiplier = 8'h5A;
        in_signed     = 1'b1;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp d0", {dig_valid, dig_shift, dig_neg, dig_zero, dig_index}, {4'b1110, 3'd0});
        tick();
        dig_ready     = 1'b0;
        in_multiplier = 8'h00;
        for (int c = 0; c < 3; c++) begin
            check("bp hold", {dig_valid, dig_shift, dig_neg, dig_zero, dig_index, dig_last},
                  {4'b1010, 3'd1, 1'b0});
            check("bp in_ready", {31'd0, in_ready}, 0);
            in_valid = (c != 1);
            tick();
        end
        check("bp hold end", {dig_valid, dig_shift, dig_neg, dig_zero, dig_index}, {4'b1010, 3'd1});
        in_valid  = 1'b0;
        dig_ready = 1'b1;
        tick();
        check("bp d2", {dig_valid, dig_shift, dig_neg, dig_zero, dig_index}, {4'b1100, 3'd2});
        tick();
        check("bp d3", {dig_valid, dig_shift, dig_neg, dig_zero, dig_index, dig_last},
              {4'b1000, 3'd3, 1'b1});
        tick();
        check_idle("bp");

        // Reset while digit 2 is presented
        in_multiplier = 8'h5A;
        in_signed     = 1'b1;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rst d2", {dig_valid, dig_index}, {1'b1, 3'd2});
        rst_n = 1'b0;
        tick();
        check_idle("midreset");
        rst_n = 1'b1;
        run_directed("01_s", 8'h01, 1'b1, {3'b000, 3'b001, 3'b001, 3'b001, 3'b000}, 4);

        // Random operands with random consumer stalls; reconstruct the value
        for (int op = 0; op < 1000; op++) begin
            logic [7:0] v;
            logic       sg;
            int         sum, cnt, budget, expv, nd;
            bit         done, idx_ok;
            v     = 8'($urandom);
            sg    = 1'($urandom_range(0, 1));
            expv  = sg ? int'($signed(v)) : int'(v);
            nd    = sg ? 4 : 5;
            sum   = 0;
            cnt   = 0;
            done  = 1'b0;
            idx_ok = 1'b1;
            in_multiplier = v;
            in_signed     = sg;
            in_valid      = 1'b1;
            tick();
            in_valid = 1'b0;
            budget   = 0;
            while (!done && budget < 200) begin
                dig_ready = 1'($urandom_range(0, 1));
                if (dig_valid && dig_ready) begin
                    if (dig_index != 3'(cnt)) idx_ok = 1'b0;
                    sum += digit_value(dig_shift, dig_neg, dig_zero) * (1 << (2 * cnt));
                    cnt++;
                    if (dig_last) done = 1'b1;
                end
                tick();
                budget++;
            end
            check("rnd done", {31'd0, done}, 1);
            check("rnd value", sum, expv);
            check("rnd count", cnt, nd);
            check("rnd index", {31'd0, idx_ok}, 1);
            check("rnd idle", {31'd0, in_ready}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
